ltz_cdc_tx: RTL and testbench
=============================

Name: ltz_cdc_tx

Overview:
ltz_cdc_tx is the source-domain end of a 2-phase (toggle) req/ack bundled-data clock-domain crossing.
- It accepts a word over a local valid/ready handshake and registers it onto a stable output bus.
- It toggles tx_req, then waits for the far domain's tx_ack toggle, synchronised internally, before accepting the next word.
- The far domain uses a synchronizer on tx_req to qualify tx_data.

Parameters:
WIDTH, 8, data width in bits.
INITVAL, {WIDTH{1'b0}}, reset value of tx_data.
SYNC_STAGES, 2, flop stages on tx_ack; legal range 2..4.
TIMEOUT, 0, cycles in WAIT_ACK before the timeout flag sets; 0 disables.

Ports:
clk  input  1  single clock.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  local word offered.
in_ready  output  1  block can accept a word (registered).
in_data  input  WIDTH  local word.
tx_data  output  WIDTH  crossing data bus; driven directly from a flop, no logic after it.
tx_req  output  1  request toggle level (registered).
tx_ack  input  1  acknowledge toggle from the far domain; asynchronous to clk.
done  output  1  one-cycle pulse when a transfer is acknowledged.
timeout  output  1  level; the current transfer exceeded TIMEOUT cycles.
proto_err  output  1  sticky; tx_ack toggled while no request was outstanding.

Behaviour:
- Reset: rst_n low at a clk posedge gives these values:
  - tx_data=INITVAL, tx_req=0, in_ready=0, done=0, timeout=0, proto_err=0.
  - All sync flops 0, counter 0, state IDLE.
- in_ready goes to 1 at the first posedge with rst_n high.
- Internal signal ack_s is the last stage of the SYNC_STAGES synchronizer on tx_ack. Its reset value is 0.
- State IDLE:
  - in_ready=1.
  - Accept occurs when in_valid & in_ready at a posedge. On accept: tx_data<=in_data, tx_req<=~tx_req, in_ready<=0, counter<=0, timeout<=0, state<=WAIT_ACK.
  - If ack_s != tx_req while in IDLE (spurious toggle): proto_err<=1, which stays set until reset. Data path is unaffected.
- State WAIT_ACK:
  - in_valid is ignored. tx_data and tx_req are held constant.
  - When ack_s == tx_req: done<=1 for one cycle, in_ready<=1, state<=IDLE.
  - Otherwise, if TIMEOUT>0, the counter increments and saturates at TIMEOUT. When it reaches TIMEOUT, timeout<=1.
  - The block stays in WAIT_ACK after a timeout; it never abandons a request, because that would desynchronise the toggle phase.
  - timeout clears on the next accept or on reset.
- Latency with the far side echoing tx_ack=tx_req combinationally:
  - Accept at edge 0, done high after edge SYNC_STAGES+1, in_ready high after the same edge.
  - Next accept is possible at edge SYNC_STAGES+2, so throughput is 1 word per SYNC_STAGES+2 cycles.
- done and in_ready rising occur in the same cycle. A word offered with in_valid held high is accepted at the next edge.
- Counter width is clog2(TIMEOUT+1), minimum 1 bit.
- Reset mid-operation returns everything to the reset state immediately. The far domain must be reset in the same window, because tx_req phase returns to 0.

Decomposition:
- Package ltz_cdc_pkg holds:
  - The state encoding: IDLE=1'b0, WAIT_ACK=1'b1.
  - A clog2 constant function.
  - SYNC_STAGES legal bounds (min 2, max 4).
- Sub-module ltz_sync_n: parameterised STAGES/WIDTH flop chain with synchronous active-low reset to 0. It is instantiated once, on tx_ack.
- The FSM, data register and timeout counter stay in ltz_cdc_tx.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with in_valid=1 and tx_ack=1 -> tx_data=INITVAL, tx_req=0, in_ready=0, proto_err=0. Release rst_n -> in_ready=1 next edge. proto_err=1 two edges after that, because tx_ack=1 is stuck while IDLE.
- Loopback (tx_ack=tx_req), SYNC_STAGES=2: send 0xA5 at edge 0 -> tx_data=0xA5 and tx_req=1 after edge 0; done pulse after edge 3. Send 0x3C at edge 4 -> tx_req=0 and done after edge 7.
- Delayed ack: far side echoes 7 cycles late; offer 0x11 then 0x22 with in_valid held high -> 0x11 held on tx_data for the whole wait. 0x22 is not accepted until after done. No data loss or duplication.
- Timeout: TIMEOUT=16, tx_ack never toggles -> timeout=1 after 16 WAIT_ACK cycles, state stays WAIT_ACK. Then toggle tx_ack -> done after SYNC_STAGES+1 edges; timeout clears on the next accept.
- Spurious ack in IDLE: toggle tx_ack with no request outstanding -> proto_err=1 after SYNC_STAGES+1 edges and stays set. The next transfer still completes with the correct data.
- Reset mid-WAIT_ACK: assert rst_n=0 for 1 cycle during a wait -> all outputs at their reset values on the next edge; in_ready=1 one edge after release.

Source files
------------

// File: rtl/ltz_cdc_pkg.sv
// Shared definitions for the toggle-handshake CDC transmitter: state encoding,
// synchronizer depth bounds and a counter-width helper.
package ltz_cdc_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // ceil(log2(value)), never less than 1 so a disabled timeout still has a legal vector
  function automatic int clog2_min1(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ltz_sync_n.sv
// Multi-flop synchronizer chain with synchronous active-low reset to zero.
// Used on the far-domain acknowledge toggle.
module ltz_sync_n #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0][WIDTH-1:0] chain_q;
  logic [STAGES-1:0][WIDTH-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) chain_q <= '0;
    else        chain_q <= chain_d;
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/ltz_cdc_tx.sv
// Source end of a 2-phase req/ack bundled-data crossing: registers a word onto
// tx_data, toggles tx_req, then waits for the synchronised tx_ack toggle.
module ltz_cdc_tx
  import ltz_cdc_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] INITVAL     = {WIDTH{1'b0}},
  parameter int               SYNC_STAGES = 2,
  parameter int               TIMEOUT     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             done,
  output logic             timeout,
  output logic             proto_err
);

  // Out-of-range depths are pulled back into the supported window
  localparam int SYNC_N = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN :
                          (SYNC_STAGES > SYNC_STAGES_MAX) ? SYNC_STAGES_MAX : SYNC_STAGES;
  localparam int CNT_W  = clog2_min1(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   tx_data_q, tx_data_d;
  logic               tx_req_q, tx_req_d;
  logic               in_ready_q, in_ready_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               proto_err_q, proto_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ack_s;
  logic               accept;
  logic               ack_match;

  ltz_sync_n #(
    .STAGES (SYNC_N),
    .WIDTH  (1)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (tx_ack),
    .q     (ack_s)
  );

  assign accept    = (state_q == IDLE) && in_valid && in_ready_q;
  assign ack_match = (ack_s == tx_req_q);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept)    state_d = WAIT_ACK;
      WAIT_ACK: if (ack_match) state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_data_d   = tx_data_q;
    tx_req_d    = tx_req_q;
    in_ready_d  = in_ready_q;
    done_d      = 1'b0;
    timeout_d   = timeout_q;
    proto_err_d = proto_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        // A phase mismatch with nothing outstanding means the far side toggled on its own
        if (!ack_match) proto_err_d = 1'b1;
        if (accept) begin
          tx_data_d  = in_data;
          tx_req_d   = ~tx_req_q;
          in_ready_d = 1'b0;
          cnt_d      = '0;
          timeout_d  = 1'b0;
        end
      end
      WAIT_ACK: begin
        if (ack_match) begin
          done_d     = 1'b1;
          in_ready_d = 1'b1;
        end else if (TIMEOUT > 0) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_MAX) timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data_q   <= INITVAL;
      tx_req_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      tx_data_q   <= tx_data_d;
      tx_req_q    <= tx_req_d;
      in_ready_q  <= in_ready_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_req    = tx_req_q;
  assign in_ready  = in_ready_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_ltz_cdc_tx.sv
// Self-checking bench for ltz_cdc_tx: directed handshake scenarios plus random
// words and ack delays checked against a transfer-level timing model.
module tb_ltz_cdc_tx;

  localparam int         WIDTH   = 8;
  localparam logic [7:0] INITVAL = 8'hC3;
  localparam int         SYNC    = 2;
  localparam int         TO      = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [WIDTH-1:0] tx_data;
  logic             tx_req;
  logic             tx_ack;
  logic             done;
  logic             timeout;
  logic             proto_err;

  logic             loop_mode = 1'b0;
  logic             ack_man = 1'b0;

  int               n_checks = 0;
  int               n_errors = 0;
  int               done_seen = 0;
  int               exp_dones = 0;
  int               xfer_id = 0;
  logic             phase = 1'b0;
  logic             exp_perr = 1'b0;
  logic [WIDTH-1:0] cur_word = '0;

  always #5 clk = ~clk;

  // Far side: either echoes tx_req directly or follows a bench-controlled level
  assign tx_ack = loop_mode ? tx_req : ack_man;

  ltz_cdc_tx #(
    .WIDTH       (WIDTH),
    .INITVAL     (INITVAL),
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .tx_ack    (tx_ack),
    .done      (done),
    .timeout   (timeout),
    .proto_err (proto_err)
  );

  always @(negedge clk) begin
    if (done) done_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"}, tx_data, INITVAL);
    check_eq({tag, "_req"}, tx_req, 0);
    check_eq({tag, "_rdy"}, in_ready, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_to"}, timeout, 0);
    check_eq({tag, "_perr"}, proto_err, 0);
  endtask

  // Offer a word and take the edge on which it is accepted
  task automatic accept_word(input logic [WIDTH-1:0] w);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && waited < 64) begin
      tick();
      waited++;
    end
    if (!in_ready) check_eq("rdy_wait", in_ready, 1);
    tick();
    phase    = ~phase;
    cur_word = w;
    check_eq("acc_data", tx_data, w);
    check_eq("acc_req", tx_req, phase);
    check_eq("acc_rdy", in_ready, 0);
    check_eq("acc_done", done, 0);
    check_eq("acc_to", timeout, 0);
    check_eq("acc_perr", proto_err, exp_perr);
  endtask

  // Far side answers d edges after the accept edge; done follows SYNC+1 edges later
  task automatic finish_xfer(input int d);
    logic exp_to;
    for (int k = 1; k <= d + SYNC; k++) begin
      if (k == d + 1) ack_man = phase;
      tick();
      check_eq("wait_done", done, 0);
      check_eq("wait_rdy", in_ready, 0);
      check_eq("wait_data", tx_data, cur_word);
      check_eq("wait_req", tx_req, phase);
      check_eq("wait_to", timeout, (k >= TO));
    end
    tick();
    exp_to = (d + SYNC >= TO);
    check_eq("fin_done", done, 1);
    check_eq("fin_rdy", in_ready, 1);
    check_eq("fin_data", tx_data, cur_word);
    check_eq("fin_to", timeout, exp_to);
    check_eq("fin_perr", proto_err, exp_perr);
    exp_dones++;
    xfer_id++;
    $display("xfer %0d data=0x%02h ack_delay=%0d timeout=%0b", xfer_id, cur_word, d, exp_to);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held with stimulus active and tx_ack stuck high
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    ack_man  = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n    = 1'b1;
    in_valid = 1'b0;
    tick();
    check_eq("rel_rdy", in_ready, 1);
    check_eq("rel_perr0", proto_err, 0);
    tick();
    check_eq("rel_perr1", proto_err, 0);
    tick();
    check_eq("rel_perr2", proto_err, 1);
    $display("reset: stuck ack flagged");

    rst_n   = 1'b0;
    ack_man = 1'b0;
    repeat (2) tick();
    check_eq("rst2_perr", proto_err, 0);
    rst_n = 1'b1;
    phase = 1'b0;
    tick();
    check_eq("rst2_rdy", in_ready, 1);

    // Loopback: far side echoes tx_req directly
    loop_mode = 1'b1;
    accept_word(8'hA5);
    finish_xfer(0);
    accept_word(8'h3C);
    in_valid = 1'b0;
    finish_xfer(0);
    ack_man   = phase;
    loop_mode = 1'b0;

    // Delayed ack with the next word already waiting
    accept_word(8'h11);
    in_data = 8'h22;
    finish_xfer(7);
    accept_word(8'h22);
    in_valid = 1'b0;
    finish_xfer(0);

    // Timeout: ack withheld past TIMEOUT cycles, flag persists into IDLE
    accept_word(8'h5E);
    in_valid = 1'b0;
    finish_xfer(25);
    tick();
    check_eq("to_hold", timeout, 1);
    check_eq("to_idle_done", done, 0);

    // Random words, random ack delays, junk on in_valid during the wait
    for (int n = 0; n < 25; n++) begin
      int d;
      int gap;
      logic [WIDTH-1:0] w;
      w   = WIDTH'($urandom);
      d   = $urandom_range(0, 20);
      gap = $urandom_range(0, 3);
      accept_word(w);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = WIDTH'($urandom);
      finish_xfer(d);
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        tick();
        check_eq("gap_rdy", in_ready, 1);
        check_eq("gap_done", done, 0);
      end
    end

    // Reset in the middle of a wait
    accept_word(8'h77);
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n   = 1'b0;
    ack_man = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    phase = 1'b0;
    tick();
    check_eq("midrst_rdy", in_ready, 1);
    check_eq("midrst_req", tx_req, 0);
    $display("reset mid-wait: outputs returned to reset values");

    // Spurious ack toggle while idle
    ack_man = ~phase;
    for (int k = 1; k <= SYNC; k++) begin
      tick();
      check_eq("spur_pre", proto_err, 0);
    end
    tick();
    exp_perr = 1'b1;
    check_eq("spur_set", proto_err, 1);
    repeat (3) tick();
    check_eq("spur_sticky", proto_err, 1);
    accept_word(8'h96);
    in_valid = 1'b0;
    tick();
    check_eq("spur_done", done, 1);
    check_eq("spur_data", tx_data, 8'h96);
    check_eq("spur_rdy", in_ready, 1);
    check_eq("spur_perr", proto_err, 1);
    exp_dones++;
    $display("spurious ack: proto_err sticky, data 0x96 delivered");

    tick();
    tick();
    check_eq("done_count", done_seen, exp_dones);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
